// File: rtl/counter_seek_driver_pkg.sv
// Shared types and helpers for the stepped-counter seek driver.
package counter_seek_driver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAN,
        PULSE,
        GAP,
        FINISH
    } state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

    // A zero gap still needs a 1-bit counter to keep the declarations legal.
    function automatic int gap_cnt_width(input int pulse_gap);
        return (pulse_gap < 1) ? 1 : $clog2(pulse_gap + 1);
    endfunction

endpackage

// File: rtl/counter_seek_driver_if.sv
// Request/step bus between the sequencer, the seek driver and the stepped counter.
interface counter_seek_driver_if #(
    parameter int WIDTH = 8
);
    logic             REQ;
    logic [WIDTH-1:0] TARGET;
    logic             ABORT;
    logic             SYNC;
    logic             UP;
    logic             DOWN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SHADOW;

    modport master (
        output REQ, TARGET, ABORT, SYNC,
        input  UP, DOWN, BUSY, DONE, SHADOW
    );

    modport slave (
        input  REQ, TARGET, ABORT, SYNC,
        output UP, DOWN, BUSY, DONE, SHADOW
    );
endinterface

// File: rtl/counter_seek_driver_ring_distance.sv
// Shortest path around a ring of MAX_VALUE+1 positions; ties resolve upward.
module ring_distance
    import counter_seek_driver_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] tgt_i,
    input  logic [WIDTH-1:0] max_value_i,
    output dir_e             dir_o,
    output logic [WIDTH-1:0] steps_o
);
    logic [WIDTH:0] modulus;
    logic [WIDTH:0] cur_ext;
    logic [WIDTH:0] tgt_ext;
    logic [WIDTH:0] fwd;
    logic [WIDTH:0] back;

    always_comb begin
        cur_ext = {1'b0, cur_i};
        tgt_ext = {1'b0, tgt_i};
        modulus = {1'b0, max_value_i} + (WIDTH+1)'(1);
        fwd     = (tgt_i >= cur_i) ? (tgt_ext - cur_ext) : (tgt_ext + modulus - cur_ext);
        back    = (cur_i >= tgt_i) ? (cur_ext - tgt_ext) : (cur_ext + modulus - tgt_ext);
        // The shorter leg is at most half the modulus, so it fits in WIDTH bits.
        if (fwd <= back) begin
            dir_o   = DIR_UP;
            steps_o = fwd[WIDTH-1:0];
        end else begin
            dir_o   = DIR_DOWN;
            steps_o = back[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/counter_seek_driver.sv
// Steps a pulse-only ring counter to a requested value, tracking its position in SHADOW.
module counter_seek_driver
    import counter_seek_driver_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 255,
    parameter int PULSE_GAP = 1
) (
    input  logic                 CLOCK,
    input  logic                 RST,
    counter_seek_driver_if.slave bus
);
    localparam int               GW       = gap_cnt_width(PULSE_GAP);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VALUE);
    localparam logic [GW-1:0]    GAP_LOAD = (PULSE_GAP > 0) ? GW'(PULSE_GAP - 1) : '0;

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d, plan_dir;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] plan_steps;
    logic [WIDTH-1:0] shadow_stepped;
    logic [WIDTH-1:0] rem_dec;

    ring_distance #(.WIDTH(WIDTH)) u_dist (
        .cur_i       (shadow_q),
        .tgt_i       (target_q),
        .max_value_i (MAX_V),
        .dir_o       (plan_dir),
        .steps_o     (plan_steps)
    );

    always_comb begin
        if (dir_q == DIR_UP) begin
            shadow_stepped = (shadow_q == MAX_V) ? '0 : shadow_q + WIDTH'(1);
        end else begin
            shadow_stepped = (shadow_q == '0) ? MAX_V : shadow_q - WIDTH'(1);
        end
        rem_dec = remaining_q - WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        target_d    = target_q;
        shadow_d    = shadow_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        case (state_q)
            IDLE: begin
                if (bus.SYNC) shadow_d = '0;
                if (bus.REQ) begin
                    target_d = (bus.TARGET > MAX_V) ? MAX_V : bus.TARGET;
                    state_d  = PLAN;
                end
            end
            PLAN: begin
                dir_d       = plan_dir;
                remaining_d = plan_steps;
                state_d     = (plan_steps == '0) ? FINISH : PULSE;
            end
            PULSE: begin
                shadow_d    = shadow_stepped;
                remaining_d = rem_dec;
                if (rem_dec == '0) begin
                    state_d = FINISH;
                end else if (bus.ABORT) begin
                    state_d = IDLE;
                end else if (PULSE_GAP == 0) begin
                    state_d = PULSE;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (bus.ABORT) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // External clear mid-move: the counter is now at 0 and the move is dead.
        if (bus.SYNC && (state_q != IDLE)) begin
            shadow_d = '0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RST) begin
            state_q     <= IDLE;
            dir_q       <= DIR_UP;
            target_q    <= '0;
            shadow_q    <= '0;
            remaining_q <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            target_q    <= target_d;
            shadow_q    <= shadow_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
        end
    end

    assign bus.UP     = (state_q == PULSE) && (dir_q == DIR_UP);
    assign bus.DOWN   = (state_q == PULSE) && (dir_q == DIR_DOWN);
    assign bus.BUSY   = (state_q != IDLE);
    assign bus.DONE   = (state_q == FINISH);
    assign bus.SHADOW = shadow_q;
endmodule
